lcd_frame_writer: RTL and testbench

- Upstream feeder for the HD44780-style LCD driver on the 2x16 character display.
- Holds a 32-character frame buffer that the host writes at any time.
- On a refresh request, streams 34 9-bit words {rs, data[7:0]} to the driver: line-0 address command, 16 characters, line-1 address command, 16 characters.
- Paces itself purely on the driver's busy_flag; never times LCD delays itself.

---
 rtl/lcd_frame_writer_pkg.sv | 29 ++
 rtl/lcd_frame_writer_if.sv | 29 ++
 rtl/lcd_frame_writer_char_buffer.sv | 28 ++
 rtl/lcd_frame_writer.sv | 160 ++++++++++++++++
 tb/tb_lcd_frame_writer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_frame_writer_pkg.sv
// lcd_pkg: shared constants, FSM state type and buffer address helper for the
// LCD frame writer (2x16 HD44780-style display feeder).
// No ports; imported by lcd_frame_writer and its testbench.
package lcd_pkg;

  localparam logic [7:0] CMD_LINE0   = 8'h80;  // set DDRAM address, line 0 col 0
  localparam logic [7:0] CMD_LINE1   = 8'hC0;  // set DDRAM address, line 1 col 0
  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam int         FRAME_WORDS = 34;
  localparam logic [8:0] IDLE_WORD   = 9'h080; // harmless word parked on d_out

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT_IDLE,
    S_WAIT_ACCEPT
  } state_t;

  // Frame word index -> character buffer address. Index 0 and the line-1
  // command index carry no character, so their result is unused.
  function automatic logic [4:0] buf_addr(input logic [5:0] idx, input int cols);
    logic [5:0] a;
    a = (idx <= 6'(cols)) ? idx - 6'd1 : idx - 6'd2;
    return a[4:0];
  endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// lcd_frame_writer_if: groups the host write port, refresh request and the
// LCD driver handshake.
//   wr_en/wr_addr/wr_data : host character write (addr 0-15 line 0, 16-31 line 1)
//   refresh               : single-cycle request to send the frame
//   lcd_busy              : busy_flag from the LCD driver
//   d_out                 : {rs, data[7:0]} to the driver's d_in
//   data_ready/frame_busy/frame_done : frame status
// master = host/driver side, slave = lcd_frame_writer.
interface lcd_frame_writer_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       refresh;
  logic       lcd_busy;
  logic [8:0] d_out;
  logic       data_ready;
  logic       frame_busy;
  logic       frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, refresh, lcd_busy,
    input  d_out, data_ready, frame_busy, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, refresh, lcd_busy,
    output d_out, data_ready, frame_busy, frame_done
  );
endinterface

// File: rtl/lcd_frame_writer_char_buffer.sv
// lcd_char_buffer: 32x8 simple dual-port character RAM.
//   clock            : system clock
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr     : synchronous read port, 1-cycle latency
//   o_rdata          : read data (holds while i_re is low)
// A read and write to the same address in one cycle returns the old data.
// No reset: the parent clears the contents through the write port.
module lcd_char_buffer (
  input  logic       clock,
  input  logic       i_we,
  input  logic [4:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic       i_re,
  input  logic [4:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [32];
  logic [7:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: holds a 32-character frame buffer and, on refresh,
// streams 34 words to the LCD driver: line-0 address, 16 chars, line-1
// address, 16 chars. Pacing comes only from the driver's busy flag; a word
// counts as accepted on the rising edge of lcd_busy.
//   clock          : 50 MHz system clock
//   internal_reset : synchronous active-high reset; re-clears the buffer
//   bus            : lcd_frame_writer_if.slave (host port + driver handshake)
// Parameters: NUM_COLS characters per line, AUTO_REFRESH restarts frames.
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int NUM_COLS     = 16,
  parameter bit AUTO_REFRESH = 1'b0
) (
  input  logic             clock,
  input  logic             internal_reset,
  lcd_frame_writer_if.slave bus
);

  localparam logic [5:0] LINE1_IDX = 6'(NUM_COLS + 1);
  localparam logic [5:0] LAST_IDX  = 6'(FRAME_WORDS - 1);

  state_t     r_state, w_state_nx;
  logic [5:0] r_idx;
  logic [4:0] r_clr;
  logic       r_pending;
  logic       r_busy_q;
  logic [8:0] r_d_out;
  logic       r_data_ready;
  logic       r_frame_busy;
  logic       r_frame_done;

  logic       w_start, w_load, w_accept;
  logic       w_rise, w_last, w_frame_busy;
  logic       w_we, w_re;
  logic [4:0] w_waddr, w_raddr;
  logic [7:0] w_wdata, w_rdata;
  logic [8:0] w_word;

  assign w_rise       = bus.lcd_busy & ~r_busy_q;
  assign w_last       = (r_idx == LAST_IDX);
  // The clear sweep counts as busy so the host sees the writer as unavailable.
  assign w_frame_busy = r_frame_busy | (r_state == S_CLEAR);

  // Clear sweep owns the write port; host writes are dropped meanwhile.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = bus.wr_addr;
    w_wdata = bus.wr_data;
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr;
      w_wdata = CHAR_SPACE;
    end else if (!internal_reset) begin
      w_we    = bus.wr_en;
    end
  end

  // Read only in FETCH so a character is sampled exactly once per frame word.
  assign w_re    = (r_state == S_FETCH);
  assign w_raddr = buf_addr(r_idx, NUM_COLS);

  lcd_char_buffer u_buf (
    .clock   (clock),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    if (r_idx == 6'd0)           w_word = {1'b0, CMD_LINE0};
    else if (r_idx == LINE1_IDX) w_word = {1'b0, CMD_LINE1};
    else                         w_word = {1'b1, w_rdata};
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_load     = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      S_CLEAR:
        if (r_clr == 5'd31) w_state_nx = S_IDLE;
      S_IDLE:
        if (bus.refresh || r_pending || AUTO_REFRESH) begin
          w_start    = 1'b1;
          w_state_nx = S_FETCH;
        end
      S_FETCH:
        w_state_nx = S_LOAD;
      // Present a word only while the driver is busy; the driver samples on
      // the first low cycle, so loading inside a low window could let it
      // write the stale word and raise busy for the wrong one.
      S_LOAD:
        if (bus.lcd_busy) begin
          w_load     = 1'b1;
          w_state_nx = S_WAIT_IDLE;
        end
      S_WAIT_IDLE:
        if (!bus.lcd_busy) w_state_nx = S_WAIT_ACCEPT;
      S_WAIT_ACCEPT:
        if (w_rise) begin
          w_accept   = 1'b1;
          w_state_nx = w_last ? S_IDLE : S_FETCH;
        end
      default:
        w_state_nx = S_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (internal_reset) begin
      r_state      <= S_CLEAR;
      r_idx        <= 6'd0;
      r_clr        <= 5'd0;
      r_pending    <= 1'b0;
      r_busy_q     <= 1'b0;
      r_d_out      <= IDLE_WORD;
      r_data_ready <= 1'b0;
      r_frame_busy <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_busy_q     <= bus.lcd_busy;
      r_frame_done <= 1'b0;
      if (r_state == S_CLEAR) r_clr <= r_clr + 5'd1;
      // Requests during a frame collapse into a single pending restart.
      if (w_start) begin
        r_idx        <= 6'd0;
        r_frame_busy <= 1'b1;
        r_pending    <= 1'b0;
      end else if (bus.refresh && w_frame_busy) begin
        r_pending    <= 1'b1;
      end
      if (w_load) begin
        r_d_out      <= w_word;
        r_data_ready <= 1'b1;
      end
      if (w_accept) begin
        r_data_ready <= 1'b0;
        if (w_last) begin
          r_d_out      <= IDLE_WORD;
          r_frame_busy <= 1'b0;
          r_frame_done <= 1'b1;
        end else begin
          r_idx        <= r_idx + 6'd1;
        end
      end
    end
  end

  assign bus.d_out      = r_d_out;
  assign bus.data_ready = r_data_ready;
  assign bus.frame_busy = w_frame_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Testbench for lcd_frame_writer with a behavioural busy-flag LCD driver.
module tb_lcd_frame_writer;

  typedef struct { logic [4:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int idx; logic [8:0] exp; } spot_t;

  logic clock = 1'b0;
  logic rst;
  always #10 clock = ~clock;

  lcd_frame_writer_if bus();

  lcd_frame_writer dut (
    .clock          (clock),
    .internal_reset (rst),
    .bus            (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // driver model + frame_done counter
  logic [8:0] cap [$];
  int cap_base = 0;
  int n_done = 0;
  int lo_len = 2;
  int hi_len = 6;
  int drv_cnt = 0;
  bit drv_hi = 1'b1;

  // Busy high for hi_len cycles, low for lo_len; d_out latched on the first
  // low cycle. Idle parking words (0x080 with data_ready low) are not logged.
  always @(negedge clock) begin
    if (bus.frame_done) n_done++;
    if (drv_hi) begin
      bus.lcd_busy = 1'b1;
      if (drv_cnt >= hi_len - 1) begin
        bus.lcd_busy = 1'b0; drv_hi = 1'b0; drv_cnt = 0;
      end else drv_cnt++;
    end else begin
      if (drv_cnt == 0 && (bus.data_ready || bus.d_out != 9'h080))
        cap.push_back(bus.d_out);
      if (drv_cnt >= lo_len - 1) begin
        bus.lcd_busy = 1'b1; drv_hi = 1'b1; drv_cnt = 0;
      end else drv_cnt++;
    end
  end

  logic [7:0] shadow [32];
  logic [8:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clock);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_refresh();
    bus.refresh = 1'b1;
    @(negedge clock);
    bus.refresh = 1'b0;
  endtask

  function automatic int ncap();
    return cap.size() - cap_base;
  endfunction

  function automatic logic [8:0] capw(input int i);
    return (i < ncap()) ? cap[cap_base + i] : 9'h1FF;
  endfunction

  task automatic wait_done(input int target, input string nm);
    int b = 6000;
    while (n_done < target && b > 0) begin @(negedge clock); b--; end
    chk({nm, "_done_timeout"}, 32'(n_done >= target), 32'd1);
  endtask

  task automatic wait_cap(input int n, input string nm);
    int b = 6000;
    while (ncap() < n && b > 0) begin @(negedge clock); b--; end
    chk({nm, "_cap_timeout"}, 32'(ncap() >= n), 32'd1);
  endtask

  // Expected frame from the bench's own copy of the buffer.
  function automatic void push_frame();
    for (int i = 0; i < 34; i++) begin
      if (i == 0)       exp_q.push_back(9'h080);
      else if (i <= 16) exp_q.push_back({1'b1, shadow[i-1]});
      else if (i == 17) exp_q.push_back(9'h0C0);
      else              exp_q.push_back({1'b1, shadow[i-2]});
    end
  endfunction

  task automatic check_frame(input string nm);
    chk({nm, "_len"}, 32'(ncap()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", nm, i), 32'(capw(i)), 32'(exp_q[i]));
    cap_base = cap.size();
    exp_q.delete();
  endtask

  wr_t   wr_tab [5];
  spot_t spot_tab [12];

  initial begin
    int fall, bad_dout, bad_dr, base;

    wr_tab = '{'{5'd0, 8'h48}, '{5'd1, 8'h45}, '{5'd2, 8'h4C},
               '{5'd3, 8'h4C}, '{5'd4, 8'h4F}};
    spot_tab = '{'{0, 9'h080}, '{1, 9'h148}, '{2, 9'h145}, '{3, 9'h14C},
                 '{4, 9'h14C}, '{5, 9'h14F}, '{6, 9'h120}, '{16, 9'h120},
                 '{17, 9'h0C0}, '{18, 9'h120}, '{25, 9'h120}, '{33, 9'h120}};
    for (int i = 0; i < 32; i++) shadow[i] = 8'h20;

    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.refresh = 1'b0;
    tick(3);
    chk("rst_dout", 32'(bus.d_out), 32'h080);
    chk("rst_dready", 32'(bus.data_ready), 32'd0);
    chk("rst_fbusy_clear", 32'(bus.frame_busy), 32'd1);
    chk("rst_fdone", 32'(bus.frame_done), 32'd0);

    // clear sweep, driver running
    rst = 1'b0;
    fall = 0; bad_dout = 0; bad_dr = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clock);
      if (bus.d_out != 9'h080) bad_dout++;
      if (bus.data_ready) bad_dr++;
      if (!bus.frame_busy && fall == 0) fall = k;
    end
    chk("clear_fall_cycle", 32'(fall), 32'd32);
    chk("clear_dout_idle", 32'(bad_dout), 32'd0);
    chk("clear_dready", 32'(bad_dr), 32'd0);
    chk("clear_no_done", 32'(n_done), 32'd0);
    chk("clear_no_words", 32'(ncap()), 32'd0);

    // HELLO frame, table driven
    foreach (wr_tab[i]) begin
      wr(wr_tab[i].addr, wr_tab[i].data);
      shadow[wr_tab[i].addr] = wr_tab[i].data;
    end
    pulse_refresh();
    wait_done(1, "hello");
    tick(100);
    chk("hello_len", 32'(ncap()), 32'd34);
    foreach (spot_tab[i])
      chk($sformatf("hello_spot%0d", spot_tab[i].idx),
          32'(capw(spot_tab[i].idx)), 32'(spot_tab[i].exp));
    chk("hello_one_done", 32'(n_done), 32'd1);
    push_frame();
    check_frame("hello");

    // writes during a frame: buf[16] not yet read, buf[2] already sent
    pulse_refresh();
    wait_cap(6, "midwr");
    wr(5'd16, 8'h41);
    wr(5'd2, 8'h5A);
    shadow[16] = 8'h41;
    push_frame();
    shadow[2] = 8'h5A;
    wait_done(2, "midwr");
    tick(2);
    chk("midwr_w3_old", 32'(capw(3)), 32'h14C);
    chk("midwr_w18_new", 32'(capw(18)), 32'h141);
    check_frame("midwr");
    pulse_refresh();
    wait_done(3, "next");
    tick(2);
    chk("next_w3_new", 32'(capw(3)), 32'h15A);
    push_frame();
    check_frame("next");

    // three refreshes mid-frame merge into one follow-up frame
    base = n_done;
    pulse_refresh();
    wait_cap(3, "pend");
    pulse_refresh(); tick(5);
    pulse_refresh(); tick(5);
    pulse_refresh();
    wait_done(base + 2, "pend");
    tick(300);
    chk("pend_two_done", 32'(n_done - base), 32'd2);
    push_frame();
    push_frame();
    check_frame("pend");

    // reset at idx 20
    pulse_refresh();
    wait_cap(21, "midrst");
    base = n_done;
    rst = 1'b1;
    @(negedge clock);
    chk("midrst_dout", 32'(bus.d_out), 32'h080);
    chk("midrst_dready", 32'(bus.data_ready), 32'd0);
    chk("midrst_fbusy", 32'(bus.frame_busy), 32'd1);
    rst = 1'b0;
    wr(5'd0, 8'h58);
    tick(40);
    chk("midrst_no_done", 32'(n_done), 32'(base));
    chk("midrst_fbusy_low", 32'(bus.frame_busy), 32'd0);
    cap_base = cap.size();
    for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
    pulse_refresh();
    wait_done(base + 1, "spaces");
    tick(2);
    push_frame();
    check_frame("spaces");

    // minimum busy windows, distinct characters, five frames
    for (int i = 0; i < 32; i++) begin
      wr(5'(i), 8'h41 + 8'(i));
      shadow[i] = 8'h41 + 8'(i);
    end
    lo_len = 2; hi_len = 3;
    tick(20);
    cap_base = cap.size();
    for (int f = 0; f < 5; f++) begin
      base = n_done;
      pulse_refresh();
      wait_done(base + 1, $sformatf("fast%0d", f));
      tick(2);
      push_frame();
      check_frame($sformatf("fast%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
